// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl_if
// Brief   : Hazard/stall signal bundle between the pipeline and its controller.
// Revision: 1.0
// ============================================================================
interface pipe_hazard_ctrl_if;
    logic [2:0]  id_rs;
    logic [2:0]  id_rt;
    logic        id_reads_rs;
    logic        id_reads_rt;
    logic [2:0]  ex_dst;
    logic        ex_regwrite;
    logic [2:0]  mem_dst;
    logic        mem_regwrite;
    logic        ex_redirect;
    logic        mem_busy;
    logic        halt_in;
    logic        pc_en;
    logic        ifid_en;
    logic        idex_en;
    logic        exmem_en;
    logic        main_stall;
    logic        flush_ifid;
    logic        stall_mem_stall;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic        mem_timeout;

    modport master (
        output id_rs, id_rt, id_reads_rs, id_reads_rt, ex_dst, ex_regwrite,
               mem_dst, mem_regwrite, ex_redirect, mem_busy, halt_in,
        input  pc_en, ifid_en, idex_en, exmem_en, main_stall, flush_ifid,
               stall_mem_stall, state, stall_cnt, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_reads_rs, id_reads_rt, ex_dst, ex_regwrite,
               mem_dst, mem_regwrite, ex_redirect, mem_busy, halt_in,
        output pc_en, ifid_en, idex_en, exmem_en, main_stall, flush_ifid,
               stall_mem_stall, state, stall_cnt, mem_timeout
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : Stall/flush/enable control for a 5-stage pipeline without forwarding.
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl (
    input  wire logic         clk,
    input  wire logic         rst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MEMWAIT = 2'b01,
        ST_HALTED  = 2'b10
    } state_t;

    localparam logic [7:0]  C_WAIT_MAX  = 8'hFF;
    localparam logic [15:0] C_STALL_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic        redirect_pend_q, redirect_pend_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic w_raw, w_halted;
    logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
    logic w_main_stall, w_flush_ifid, w_stall_mem_stall;

    always_comb begin
        w_raw = (hz.id_reads_rs & ((hz.ex_regwrite  & (hz.ex_dst  == hz.id_rs)) |
                                   (hz.mem_regwrite & (hz.mem_dst == hz.id_rs)))) |
                (hz.id_reads_rt & ((hz.ex_regwrite  & (hz.ex_dst  == hz.id_rt)) |
                                   (hz.mem_regwrite & (hz.mem_dst == hz.id_rt))));
        w_halted = (state_q == ST_HALTED);
    end

    // Priority: halt, memory wait, redirect (wins over RAW: wrong-path), RAW.
    always_comb begin
        w_pc_en           = 1'b1;
        w_ifid_en         = 1'b1;
        w_idex_en         = 1'b1;
        w_exmem_en        = 1'b1;
        w_main_stall      = 1'b0;
        w_flush_ifid      = 1'b0;
        w_stall_mem_stall = 1'b0;
        if (w_halted) begin
            w_pc_en    = 1'b0;
            w_ifid_en  = 1'b0;
            w_idex_en  = 1'b0;
            w_exmem_en = 1'b0;
        end else if (hz.mem_busy) begin
            w_pc_en           = 1'b0;
            w_ifid_en         = 1'b0;
            w_idex_en         = 1'b0;
            w_exmem_en        = 1'b0;
            w_stall_mem_stall = 1'b1;
        end else if (redirect_pend_q | hz.ex_redirect) begin
            w_flush_ifid = 1'b1;
            w_main_stall = 1'b1;
        end else if (w_raw) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_main_stall = 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        redirect_pend_d = redirect_pend_q;
        wait_cnt_d      = wait_cnt_q;
        stall_cnt_d     = stall_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (hz.mem_busy) begin
                    state_d    = ST_MEMWAIT;
                    wait_cnt_d = 8'd0;
                end else if (hz.halt_in) begin
                    state_d = ST_HALTED;
                end
            end
            ST_MEMWAIT: begin
                if (wait_cnt_q != C_WAIT_MAX)
                    wait_cnt_d = wait_cnt_q + 8'd1;
                if (!hz.mem_busy)
                    state_d = hz.halt_in ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
        // A redirect seen during a memory wait is held until the wait ends.
        if (!w_halted) begin
            redirect_pend_d = hz.mem_busy & (redirect_pend_q | hz.ex_redirect);
            if (!w_pc_en && (stall_cnt_q != C_STALL_MAX))
                stall_cnt_d = stall_cnt_q + 16'd1;
        end
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == C_WAIT_MAX);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_RUN;
            redirect_pend_q <= 1'b0;
            wait_cnt_q      <= 8'd0;
            stall_cnt_q     <= 16'd0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            redirect_pend_q <= redirect_pend_d;
            wait_cnt_q      <= wait_cnt_d;
            stall_cnt_q     <= stall_cnt_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    assign hz.pc_en           = w_pc_en;
    assign hz.ifid_en         = w_ifid_en;
    assign hz.idex_en         = w_idex_en;
    assign hz.exmem_en        = w_exmem_en;
    assign hz.main_stall      = w_main_stall;
    assign hz.flush_ifid      = w_flush_ifid;
    assign hz.stall_mem_stall = w_stall_mem_stall;
    assign hz.state           = state_q;
    assign hz.stall_cnt       = stall_cnt_q;
    assign hz.mem_timeout     = mem_timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : Directed vector table plus multi-cycle sequences for pipe_hazard_ctrl.
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt;

    pipe_hazard_ctrl_if hz();
    pipe_hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz));

    always #5 clk = ~clk;

    // {pc_en, ifid_en, idex_en, exmem_en, main_stall, flush_ifid}
    logic [5:0] outs;
    logic [3:0] ens;
    assign outs = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.main_stall, hz.flush_ifid};
    assign ens  = outs[5:2];

    typedef struct packed {
        logic [2:0] id_rs;
        logic [2:0] id_rt;
        logic       rd_rs;
        logic       rd_rt;
        logic [2:0] ex_dst;
        logic       ex_rw;
        logic [2:0] mem_dst;
        logic       mem_rw;
        logic       redir;
        logic [5:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.id_rs = 3'd0; hz.id_rt = 3'd0; hz.id_reads_rs = 1'b0; hz.id_reads_rt = 1'b0;
        hz.ex_dst = 3'd0; hz.ex_regwrite = 1'b0; hz.mem_dst = 3'd0; hz.mem_regwrite = 1'b0;
        hz.ex_redirect = 1'b0; hz.mem_busy = 1'b0; hz.halt_in = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        hz.id_rs = v.id_rs; hz.id_rt = v.id_rt; hz.id_reads_rs = v.rd_rs; hz.id_reads_rt = v.rd_rt;
        hz.ex_dst = v.ex_dst; hz.ex_regwrite = v.ex_rw; hz.mem_dst = v.mem_dst;
        hz.mem_regwrite = v.mem_rw; hz.ex_redirect = v.redir;
        hz.mem_busy = 1'b0; hz.halt_in = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           rs    rt    rrs   rrt   exd   exw   memd  memw  red   exp
        vecs[0]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 6'b111100};
        vecs[1]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 6'b001110};
        vecs[2]  = '{3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 6'b111100};
        vecs[3]  = '{3'd0, 3'd5, 1'b0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 6'b111100};
        vecs[4]  = '{3'd0, 3'd5, 1'b0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0, 6'b001110};
        vecs[5]  = '{3'd0, 3'd5, 1'b0, 1'b1, 3'd0, 1'b0, 3'd5, 1'b0, 1'b0, 6'b111100};
        vecs[6]  = '{3'd2, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 6'b111100};
        vecs[7]  = '{3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1, 6'b111111};
        vecs[8]  = '{3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 6'b111111};
        vecs[9]  = '{3'd0, 3'd7, 1'b0, 1'b1, 3'd7, 1'b1, 3'd0, 1'b0, 1'b0, 6'b001110};
        vecs[10] = '{3'd1, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0, 6'b001110};
        vecs[11] = '{3'd0, 3'd0, 1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 1'b0, 1'b0, 6'b001110};
        vecs[12] = '{3'd3, 3'd4, 1'b0, 1'b1, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 6'b111100};

        // Reset state, sampled while reset is still asserted
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        chk("reset_state", 32'(hz.state), 32'd0);
        chk("reset_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        chk("reset_timeout", 32'(hz.mem_timeout), 32'd0);
        chk("reset_outs", 32'(outs), 32'b111100);
        chk("reset_smstall", 32'(hz.stall_mem_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        // Single-cycle combinational table, all in RUN
        exp_cnt = 0;
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp));
            chk($sformatf("vec%0d_smstall", i), 32'(hz.stall_mem_stall), 32'd0);
            chk($sformatf("vec%0d_stall_cnt", i), 32'(hz.stall_cnt), 32'(exp_cnt));
            if (!vecs[i].exp[5]) exp_cnt++;
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk("table_final_cnt", 32'(hz.stall_cnt), 32'(exp_cnt));
        next_cycle();

        // Memory busy for 4 cycles
        do_reset();
        for (int c = 0; c < 4; c++) begin
            hz.mem_busy = 1'b1;
            @(negedge clk);
            chk($sformatf("busy%0d_ens", c), 32'(ens), 32'b0000);
            chk($sformatf("busy%0d_smstall", c), 32'(hz.stall_mem_stall), 32'd1);
            chk($sformatf("busy%0d_state", c), 32'(hz.state), (c == 0) ? 32'd0 : 32'd1);
            next_cycle();
        end
        hz.mem_busy = 1'b0;
        @(negedge clk);
        chk("busy_end_state", 32'(hz.state), 32'd1);
        chk("busy_end_ens", 32'(ens), 32'b1111);
        chk("busy_end_stall_cnt", 32'(hz.stall_cnt), 32'd4);
        next_cycle();
        chk("busy_back_run", 32'(hz.state), 32'd0);

        // Redirect during a memory wait is deferred, applied once
        do_reset();
        for (int c = 0; c < 4; c++) begin
            hz.mem_busy    = 1'b1;
            hz.ex_redirect = (c == 1);
            @(negedge clk);
            chk($sformatf("rdbusy%0d_flush", c), 32'(hz.flush_ifid), 32'd0);
            chk($sformatf("rdbusy%0d_mstall", c), 32'(hz.main_stall), 32'd0);
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        chk("rd_apply_outs", 32'(outs), 32'b111111);
        next_cycle();
        @(negedge clk);
        chk("rd_once_outs", 32'(outs), 32'b111100);
        next_cycle();

        // Reset during MEMWAIT drops the pending redirect
        do_reset();
        hz.mem_busy    = 1'b1;
        hz.ex_redirect = 1'b1;
        next_cycle();
        hz.ex_redirect = 1'b0;
        @(negedge clk);
        chk("pre_rst_state", 32'(hz.state), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_state", 32'(hz.state), 32'd0);
        next_cycle();
        hz.mem_busy = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_drop_redirect", 32'(outs), 32'b111100);
        next_cycle();
        chk("rst_leave_run", 32'(hz.state), 32'd0);

        // Long memory wait: sticky timeout
        do_reset();
        hz.mem_busy = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 255) chk("timeout_c255", 32'(hz.mem_timeout), 32'd0);
            if (c == 256) chk("timeout_c256", 32'(hz.mem_timeout), 32'd1);
            if (c == 299) chk("timeout_state", 32'(hz.state), 32'd1);
            next_cycle();
        end
        hz.mem_busy = 1'b0;
        @(negedge clk);
        chk("timeout_after_busy", 32'(hz.mem_timeout), 32'd1);
        chk("timeout_ens", 32'(ens), 32'b1111);
        next_cycle();
        @(negedge clk);
        chk("timeout_run", 32'(hz.state), 32'd0);
        chk("timeout_sticky", 32'(hz.mem_timeout), 32'd1);
        chk("timeout_stall_cnt", 32'(hz.stall_cnt), 32'd300);
        next_cycle();

        // Halt is terminal until reset
        do_reset();
        hz.halt_in = 1'b1;
        @(negedge clk);
        chk("halt_cycle_outs", 32'(outs), 32'b111100);
        chk("halt_cycle_state", 32'(hz.state), 32'd0);
        next_cycle();
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            case (c)
                0: hz.mem_busy = 1'b1;
                1: hz.ex_redirect = 1'b1;
                2: begin hz.id_rs = 3'd2; hz.id_reads_rs = 1'b1; hz.ex_dst = 3'd2; hz.ex_regwrite = 1'b1; end
                default: begin hz.mem_busy = 1'b1; hz.ex_redirect = 1'b1; end
            endcase
            @(negedge clk);
            chk($sformatf("halted%0d_outs", c), 32'(outs), 32'b000000);
            chk($sformatf("halted%0d_smstall", c), 32'(hz.stall_mem_stall), 32'd0);
            chk($sformatf("halted%0d_state", c), 32'(hz.state), 32'd2);
            chk($sformatf("halted%0d_stall_cnt", c), 32'(hz.stall_cnt), 32'd0);
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("halt_rst_state", 32'(hz.state), 32'd0);
        chk("halt_rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        chk("halt_rst_outs", 32'(outs), 32'b111100);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
